// File: rtl/dqn_fixed_pkg.sv
// Shared Q8.8 fixed-point constants and the delta-generator state type.
// Imported by the multiplier-saturator and the weight-update generator.
package dqn_fixed_pkg;

    localparam int W    = 16;
    localparam int FRAC = 8;

    localparam logic signed [W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [W-1:0] SAT_MIN = 16'sh8000;

    localparam logic [3:0] COMMIT_CODE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        SCALE,
        PROD,
        COMMIT
    } state_t;

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational signed fixed-point multiply, floor shift by FRAC,
// and saturation back to W bits.
module fx_mul_sat
    import dqn_fixed_pkg::*;
#(
    parameter int MW = W,
    parameter int MF = FRAC
) (
    input  logic signed [MW-1:0] a,
    input  logic signed [MW-1:0] b,
    output logic signed [MW-1:0] y
);

    localparam logic signed [2*MW-1:0] HI =
        {{(MW+1){1'b0}}, {(MW-1){1'b1}}};
    localparam logic signed [2*MW-1:0] LO =
        {{(MW+1){1'b1}}, {(MW-1){1'b0}}};

    logic signed [2*MW-1:0] prod;
    logic signed [2*MW-1:0] sh;

    always_comb begin
        prod = a * b;
        sh   = prod >>> MF;
        if (sh > HI) begin
            y = {1'b0, {(MW-1){1'b1}}};
        end else if (sh < LO) begin
            y = {1'b1, {(MW-1){1'b0}}};
        end else begin
            y = sh[MW-1:0];
        end
    end

endmodule

// File: rtl/deltaw3_gen.sv
// Output-layer weight-update generator: delta_ij = lr * err_j * h_i,
// computed serially on one shared multiplier, then a commit strobe.
module deltaw3_gen
    import dqn_fixed_pkg::*;
#(
    parameter int DW = W,
    parameter int DF = FRAC,
    parameter int NH = 5,
    parameter int NO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DW-1:0]          lr,
    input  logic [NH*DW-1:0]       h_flat,
    input  logic [NO*DW-1:0]       err_flat,
    output logic [NH*NO*DW-1:0]    delta_flat,
    output logic [3:0]             ctrl,
    output logic [3:0]             sel,
    output logic                   busy,
    output logic                   done
);

    localparam int NK = NH * NO;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;
    localparam int IW = (NH > 1) ? $clog2(NH) : 1;
    localparam int JW = (NO > 1) ? $clog2(NO) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(NK - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NO - 1);

    state_t state;
    state_t nxt;

    logic [KW-1:0] k;
    logic [IW-1:0] ri;
    logic [JW-1:0] cj;

    logic signed [DW-1:0] lr_r;
    logic signed [DW-1:0] h_r   [NH];
    logic signed [DW-1:0] err_r [NO];
    logic signed [DW-1:0] p_r   [NO];
    logic [NH*NO*DW-1:0]  delta_r;

    logic signed [DW-1:0] op_a;
    logic signed [DW-1:0] op_b;
    logic signed [DW-1:0] mul_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = SCALE;
            SCALE:   if (cj == J_LAST) nxt = PROD;
            PROD:    if (k == K_LAST) nxt = COMMIT;
            COMMIT:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ctrl = 4'b0000;
        sel  = 4'b0000;
        done = 1'b0;
        busy = (state != IDLE);
        if (state == COMMIT) begin
            ctrl = COMMIT_CODE;
            sel  = COMMIT_CODE;
            done = 1'b1;
        end
    end

    // SCALE uses err_j x lr; PROD reuses the same multiplier for p_j x h_i.
    always_comb begin
        if (state == PROD) begin
            op_a = p_r[cj];
            op_b = h_r[ri];
        end else begin
            op_a = err_r[cj];
            op_b = lr_r;
        end
    end

    fx_mul_sat #(
        .MW (DW),
        .MF (DF)
    ) u_mul (
        .a (op_a),
        .b (op_b),
        .y (mul_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k       <= '0;
            ri      <= '0;
            cj      <= '0;
            lr_r    <= '0;
            delta_r <= '0;
            for (int i = 0; i < NH; i++) h_r[i] <= '0;
            for (int j = 0; j < NO; j++) begin
                err_r[j] <= '0;
                p_r[j]   <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        lr_r <= lr;
                        for (int i = 0; i < NH; i++)
                            h_r[i] <= h_flat[i*DW +: DW];
                        for (int j = 0; j < NO; j++)
                            err_r[j] <= err_flat[j*DW +: DW];
                        k  <= '0;
                        ri <= '0;
                        cj <= '0;
                    end
                end
                SCALE: begin
                    p_r[cj] <= mul_y;
                    cj      <= (cj == J_LAST) ? '0 : cj + 1'b1;
                end
                PROD: begin
                    delta_r[int'(k)*DW +: DW] <= mul_y;
                    k <= k + 1'b1;
                    if (cj == J_LAST) begin
                        cj <= '0;
                        ri <= ri + 1'b1;
                    end else begin
                        cj <= cj + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign delta_flat = delta_r;

endmodule

// File: tb/tb_deltaw3_gen.sv
// Randomised and directed bench for deltaw3_gen against an
// integer-arithmetic reference of the weight-update rule.
module tb_deltaw3_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  lr;
    logic [79:0]  h_flat;
    logic [63:0]  err_flat;
    logic [319:0] delta_flat;
    logic [3:0]   ctrl;
    logic [3:0]   sel;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    deltaw3_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .lr         (lr),
        .h_flat     (h_flat),
        .err_flat   (err_flat),
        .delta_flat (delta_flat),
        .ctrl       (ctrl),
        .sel        (sel),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] satmul(input logic signed [15:0] a,
                                           input logic signed [15:0] b);
        longint pr, q;
        pr = longint'(a) * longint'(b);
        q  = pr / 256;
        if (pr < 0 && (pr % 256) != 0) q = q - 1;
        if (q > 32767) return 16'h7FFF;
        if (q < -32768) return 16'h8000;
        return q[15:0];
    endfunction

    function automatic logic [319:0] model(input logic [15:0] l,
                                           input logic [79:0] hh,
                                           input logic [63:0] ee);
        logic [15:0]  p [4];
        logic [319:0] d;
        d = '0;
        for (int j = 0; j < 4; j++) p[j] = satmul(ee[16*j +: 16], l);
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 4; j++)
                d[16*(4*i+j) +: 16] = satmul(hh[16*i +: 16], p[j]);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one run, scrambles inputs after the start cycle and
    // records strobe/busy timing over a bounded window.
    task automatic do_run(input logic [15:0] l, input logic [79:0] hh,
                          input logic [63:0] ee, output int commit_cyc,
                          output int busy_cnt, output int strobes,
                          output int busy_last);
        lr = l; h_flat = hh; err_flat = ee; start = 1'b1;
        tick();
        start    = 1'b0;
        lr       = 16'($urandom);
        h_flat   = 80'({$urandom, $urandom, $urandom});
        err_flat = 64'({$urandom, $urandom});
        commit_cyc = -1; busy_cnt = 0; strobes = 0; busy_last = 0;
        for (int c = 1; c <= 30; c++) begin
            if (busy === 1'b1) begin
                busy_cnt++;
                busy_last = c;
            end
            if (ctrl !== 4'h0 || sel !== 4'h0 || done !== 1'b0)
                strobes++;
            if (ctrl === 4'hF && sel === 4'hF && done === 1'b1
                && commit_cyc < 0)
                commit_cyc = c;
            tick();
        end
    endtask

    task automatic check_run(input string nm, input logic [319:0] exp_d,
                             input int cc, input int bc, input int st,
                             input int bl);
        n_cmp++;
        if (delta_flat !== exp_d) begin
            n_err++;
            $display("FAIL %s delta: got %h want %h", nm, delta_flat, exp_d);
        end
        n_cmp++;
        if (cc !== 25 || st !== 1) begin
            n_err++;
            $display("FAIL %s strobe: cycle %0d count %0d want 25/1",
                     nm, cc, st);
        end
        n_cmp++;
        if (bc !== 25 || bl !== 25) begin
            n_err++;
            $display("FAIL %s busy: cycles %0d last %0d want 25/25",
                     nm, bc, bl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        lr = 16'h0100; h_flat = '1; err_flat = '1;
        tick(); tick();
        n_cmp++;
        if (delta_flat !== '0 || busy !== 1'b0 || ctrl !== 4'h0 ||
            sel !== 4'h0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: delta %h busy %b ctrl %h sel %h done %b want all 0",
                     delta_flat, busy, ctrl, sel, done);
        end
        start = 1'b0; rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wins: busy %b want 0", busy);
        end
    endtask

    task automatic test_unit();
        int cc, bc, st, bl;
        logic [319:0] exp_d;
        for (int s = 0; s < 20; s++) exp_d[16*s +: 16] = 16'h0200;
        do_run(16'h0100, {5{16'h0200}}, {4{16'h0100}}, cc, bc, st, bl);
        check_run("unit", exp_d, cc, bc, st, bl);
    endtask

    task automatic test_sign_floor();
        int cc, bc, st, bl;
        logic [79:0] hh;
        logic [63:0] ee;
        hh = {5{16'h0100}}; hh[15:0] = 16'h0080;
        ee = {4{16'h0100}}; ee[15:0] = 16'hFF00;
        do_run(16'h0100, hh, ee, cc, bc, st, bl);
        n_cmp++;
        if (delta_flat[15:0] !== 16'hFF80) begin
            n_err++;
            $display("FAIL sign_d11: got %h want ff80", delta_flat[15:0]);
        end
        check_run("sign", model(16'h0100, hh, ee), cc, bc, st, bl);
        hh = {5{16'h0100}};
        ee = {4{16'h0100}}; ee[31:16] = 16'hFFFF;
        do_run(16'h0080, hh, ee, cc, bc, st, bl);
        n_cmp++;
        if (delta_flat[31:16] !== 16'hFFFF) begin
            n_err++;
            $display("FAIL floor_d12: got %h want ffff", delta_flat[31:16]);
        end
        check_run("floor", model(16'h0080, hh, ee), cc, bc, st, bl);
    endtask

    task automatic test_saturation();
        int cc, bc, st, bl;
        logic [319:0] exp_d;
        for (int s = 0; s < 20; s++) exp_d[16*s +: 16] = 16'h7FFF;
        do_run(16'h7FFF, {5{16'h7FFF}}, {4{16'h7FFF}}, cc, bc, st, bl);
        check_run("sat_pos", exp_d, cc, bc, st, bl);
        for (int s = 0; s < 20; s++) exp_d[16*s +: 16] = 16'h8000;
        do_run(16'h7FFF, {5{16'h7FFF}}, {4{16'h8000}}, cc, bc, st, bl);
        check_run("sat_neg", exp_d, cc, bc, st, bl);
    endtask

    task automatic test_index_map();
        int cc, bc, st, bl;
        logic [79:0]  hh;
        logic [63:0]  ee;
        logic [319:0] exp_d;
        for (int i = 1; i <= 5; i++) hh[16*(i-1) +: 16] = 16'(i * 256);
        for (int j = 1; j <= 4; j++) ee[16*(j-1) +: 16] = 16'(j * 256);
        for (int i = 1; i <= 5; i++)
            for (int j = 1; j <= 4; j++)
                exp_d[16*(4*(i-1)+(j-1)) +: 16] = 16'(i * j * 256);
        do_run(16'h0100, hh, ee, cc, bc, st, bl);
        n_cmp++;
        if (delta_flat[16*18 +: 16] !== 16'h0F00) begin
            n_err++;
            $display("FAIL index_d53: got %h want 0f00",
                     delta_flat[16*18 +: 16]);
        end
        check_run("index", exp_d, cc, bc, st, bl);
    endtask

    task automatic test_random();
        int cc, bc, st, bl;
        logic [15:0] l;
        logic [79:0] hh;
        logic [63:0] ee;
        for (int r = 0; r < 6; r++) begin
            l  = 16'($urandom);
            hh = 80'({$urandom, $urandom, $urandom});
            ee = 64'({$urandom, $urandom});
            if (r >= 3) begin
                l  = l & 16'h03FF;
                hh = hh & {5{16'h83FF}};
                ee = ee & {4{16'h87FF}};
            end
            do_run(l, hh, ee, cc, bc, st, bl);
            check_run($sformatf("rand%0d", r), model(l, hh, ee),
                      cc, bc, st, bl);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] l1, l2;
        logic [79:0] h1, h2;
        logic [63:0] e1, e2;
        int strobe_cyc [$];
        l1 = 16'h0180; h1 = 80'({$urandom, $urandom, $urandom});
        e1 = 64'({$urandom, $urandom});
        l2 = 16'hFF40; h2 = 80'({$urandom, $urandom, $urandom});
        e2 = 64'({$urandom, $urandom});
        lr = l1; h_flat = h1; err_flat = e1; start = 1'b1;
        tick();
        start = 1'b0;
        lr = 16'h7FFF; h_flat = '1; err_flat = 64'h1234_5678_9ABC_DEF0;
        for (int c = 1; c <= 60; c++) begin
            if (ctrl !== 4'h0 || sel !== 4'h0 || done !== 1'b0)
                strobe_cyc.push_back(c);
            start = 1'b0;
            if (c == 10) start = 1'b1;
            if (c == 26) begin
                n_cmp++;
                if (delta_flat !== model(l1, h1, e1)) begin
                    n_err++;
                    $display("FAIL b2b_first: got %h want %h",
                             delta_flat, model(l1, h1, e1));
                end
                lr = l2; h_flat = h2; err_flat = e2; start = 1'b1;
            end
            if (c == 27) begin
                lr = '0; h_flat = '0; err_flat = '0;
            end
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (strobe_cyc.size() != 2 ||
            strobe_cyc[0] != 25 || strobe_cyc[1] != 51) begin
            n_err++;
            $display("FAIL b2b_strobes: count %0d first %0d second %0d want 2/25/51",
                     strobe_cyc.size(),
                     (strobe_cyc.size() > 0) ? strobe_cyc[0] : -1,
                     (strobe_cyc.size() > 1) ? strobe_cyc[1] : -1);
        end
        n_cmp++;
        if (delta_flat !== model(l2, h2, e2)) begin
            n_err++;
            $display("FAIL b2b_second: got %h want %h",
                     delta_flat, model(l2, h2, e2));
        end
    endtask

    task automatic test_reset_mid();
        int cc, bc, st, bl;
        int strobes;
        logic [15:0] l;
        logic [79:0] hh;
        logic [63:0] ee;
        strobes = 0;
        lr = 16'h0100; h_flat = {5{16'h0300}}; err_flat = {4{16'h0100}};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (ctrl !== 4'h0 || sel !== 4'h0 || done !== 1'b0)
                strobes++;
            rst_n = (c == 12) ? 1'b0 : 1'b1;
            if (c == 13) begin
                n_cmp++;
                if (delta_flat !== '0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL midreset_clear: delta %h busy %b want 0/0",
                             delta_flat, busy);
                end
            end
            tick();
        end
        rst_n = 1'b1;
        n_cmp++;
        if (strobes != 0) begin
            n_err++;
            $display("FAIL midreset_strobe: saw %0d want 0", strobes);
        end
        l  = 16'h0140;
        hh = 80'({$urandom, $urandom, $urandom});
        ee = 64'({$urandom, $urandom});
        do_run(l, hh, ee, cc, bc, st, bl);
        check_run("after_reset", model(l, hh, ee), cc, bc, st, bl);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        lr = '0; h_flat = '0; err_flat = '0;
        #1;
        test_reset();
        test_unit();
        test_sign_floor();
        test_saturation();
        test_index_map();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
